// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder computing som = a + b + rin over N bits,
// K bits per clock, with a start/busy/done handshake and a signed-overflow flag.
// Operands are latched on the accept edge. One K-bit slice is added per RUN
// cycle, from the least significant slice upward, with the carry rippling
// between cycles through a single flop. The result registers are updated only
// on the final RUN edge.
module serial_adder #(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] som,
  output logic         rout,
  output logic         ovf
);

  // Number of slices, and the width of the slice counter.
  localparam int S  = N / K;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] LAST = IW'(S - 1);

  // A slice width that does not divide the operand width cannot be sequenced.
  generate
    if (N < 1 || K < 1 || (N % K) != 0) begin : g_param_check
      $error("serial_adder: N must be >= 1 and K must divide N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [N-1:0]    acc_reg;
  logic [N-1:0]    acc_next;
  logic            carry_reg;
  logic [IW-1:0]   i_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [N-1:0]    som_reg;
  logic            rout_reg;
  logic            ovf_reg;

  logic [K-1:0]    a_cur;
  logic [K-1:0]    b_cur;
  logic [K:0]      slice_sum;
  logic            msb_cin;

  // Select the operand slice addressed by the slice counter.
  assign a_cur = K'(a_reg >> (K * i_reg));
  assign b_cur = K'(b_reg >> (K * i_reg));

  // K-bit slice adder. The top bit of the result is the carry out of the slice.
  assign slice_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{K{1'b0}}, carry_reg};

  // Carry into the slice MSB is recovered from its sum bit: s = a ^ b ^ cin.
  // On the final slice this is the carry into bit N-1.
  assign msb_cin = slice_sum[K-1] ^ a_cur[K-1] ^ b_cur[K-1];

  // The accumulator gets the current slice sum in slice i; all other slices
  // keep their value.
  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_acc_slice
      assign acc_next[gi*K +: K] = (i_reg == IW'(gi)) ? slice_sum[K-1:0]
                                                      : acc_reg[gi*K +: K];
    end
  endgenerate

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      i_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      som_reg   <= '0;
      rout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // done is a single-cycle pulse. DONE accepts a new start directly,
          // which allows back-to-back operations.
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= rin;
            i_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // start is ignored here. Only the latched operands are used.
          acc_reg   <= acc_next;
          carry_reg <= slice_sum[K];
          i_reg     <= i_reg + 1'b1;
          if (i_reg == LAST) begin
            som_reg   <= acc_next;
            rout_reg  <= slice_sum[K];
            ovf_reg   <= msb_cin ^ slice_sum[K];
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign som  = som_reg;
  assign rout = rout_reg;
  assign ovf  = ovf_reg;

endmodule
